// File: rtl/led_blink_driver_pkg.sv
// led_blink_driver_pkg: shared FSM state encoding, LED level helper and phase counter sizing
package led_blink_driver_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_OFF = 2'd2} state_e;
  function automatic logic led_level(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction
  function automatic int phase_w(input int on_c, input int off_c);
    return $clog2((on_c > off_c ? on_c : off_c) + 1);
  endfunction
endpackage

// File: rtl/led_blink_driver_if.sv
// led_blink_driver_if: blink request handshake
// req_valid/req_count from the requester (master), req_ready back from the driver (slave)
interface led_blink_driver_if #(parameter int COUNT_W = 4);
  logic req_valid;
  logic req_ready;
  logic [COUNT_W-1:0] req_count;
  modport master (output req_valid, output req_count, input req_ready);
  modport slave (input req_valid, input req_count, output req_ready);
endinterface

// File: rtl/led_blink_driver_phase_timer.sv
// led_blink_driver_phase_timer: loadable down-counter, tc_o high while the count is zero
// clk/rst_n clock and async active-low reset; load_i/load_val_i reload; tc_o terminal count
module led_blink_driver_phase_timer #(parameter int W = 2) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i : (count_q != '0 ? count_q - W'(1) : count_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign tc_o = count_q == '0;
endmodule

// File: rtl/led_blink_driver.sv
// led_blink_driver: blinks the LED N times per accepted request, one-cycle done at the end
// clk/rst_n clock and async active-low reset; req handshake (slave); led pin; busy; done pulse
module led_blink_driver import led_blink_driver_pkg::*; #(
  parameter int ON_CYCLES      = 50000000,
  parameter int OFF_CYCLES     = 50000000,
  parameter int COUNT_W        = 4,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  led_blink_driver_if.slave req,
  output logic              led,
  output logic              busy,
  output logic              done
);
  localparam int PW = phase_w(ON_CYCLES, OFF_CYCLES);
  localparam logic [PW-1:0] ON_LD = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LD = PW'(OFF_CYCLES - 1);
  state_e state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic done_q, done_d, tc;
  // every state change reloads the timer for the phase being entered; the IDLE reload is harmless
  led_blink_driver_phase_timer #(.W(PW)) u_timer (
    .clk,
    .rst_n,
    .load_i(state_d != state_q),
    .load_val_i(state_d == ST_ON ? ON_LD : OFF_LD),
    .tc_o(tc)
  );
  always_comb begin
    state_d = state_q;
    remaining_d = remaining_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (req.req_valid) begin
        if (req.req_count != '0) begin
          state_d = ST_ON;
          remaining_d = req.req_count;
        end else done_d = 1'b1;
      end
      ST_ON: if (tc) begin
        state_d = ST_OFF;
        remaining_d = remaining_q - COUNT_W'(1);
      end
      ST_OFF: if (tc) begin
        state_d = remaining_q != '0 ? ST_ON : ST_IDLE;
        done_d = remaining_q == '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      remaining_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      done_q <= done_d;
    end
  // led decodes state alone, so the async reset of state_q darkens the pin immediately
  assign led = led_level(state_q == ST_ON, LED_ACTIVE_LOW);
  assign busy = state_q != ST_IDLE;
  assign req.req_ready = !busy;
  assign done = done_q;
endmodule

// File: tb/tb_led_blink_driver.sv
// tb_led_blink_driver: directed and random checks of two driver instances against a timing model
module tb_led_blink_driver;
  localparam int ON = 3, OFF = 2, P = ON + OFF;
  logic clk = 1'b0, rst_n = 1'b0, valid_s = 1'b0;
  logic [3:0] count_s = 4'd0;
  logic led0, busy0, done0, led1, busy1, done1;
  int cyc = 0, checks = 0, errors = 0;
  bit acc_ok = 1'b0;
  int acc_a = 0, acc_n = 0;
  led_blink_driver_if #(.COUNT_W(4)) if0 ();
  led_blink_driver_if #(.COUNT_W(4)) if1 ();
  assign if0.req_valid = valid_s;
  assign if0.req_count = count_s;
  assign if1.req_valid = valid_s;
  assign if1.req_count = count_s;
  led_blink_driver #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .COUNT_W(4), .LED_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(if0), .led(led0), .busy(busy0), .done(done0));
  led_blink_driver #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .COUNT_W(4), .LED_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(if1), .led(led1), .busy(busy1), .done(done1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  // request accepted in cycle a with n blinks: busy for cycles a+1 .. a+n*P, lit for the first ON of each P
  function automatic void model(input int c, output bit b, output bit lit, output bit d);
    int t = c - acc_a - 1;
    b = acc_ok && acc_n > 0 && t >= 0 && t < acc_n * P;
    lit = b && (t % P) < ON;
    d = acc_ok && c == acc_a + 1 + acc_n * P;
  endfunction
  always @(negedge clk) begin
    bit eb, el, ed;
    if (!rst_n) acc_ok = 1'b0;
    model(cyc, eb, el, ed);
    chk("led0", led0, el);
    chk("busy0", busy0, eb);
    chk("ready0", if0.req_ready, !eb);
    chk("done0", done0, ed);
    chk("led1", led1, !el);
    chk("busy1", busy1, eb);
    chk("ready1", if1.req_ready, !eb);
    chk("done1", done1, ed);
    if (rst_n && !eb && valid_s) begin
      acc_ok = 1'b1;
      acc_a = cyc;
      acc_n = count_s;
    end
  end
  task automatic wait_cyc(input int k);
    repeat (k - cyc) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input int n, output int a);
    @(posedge clk);
    #2 valid_s = 1'b1;
    count_s = 4'(n);
    a = cyc;
    @(posedge clk);
    #2 valid_s = 1'b0;
    count_s = 4'($urandom);
  endtask
  initial begin
    int a, lows, edges;
    logic prev;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    a = cyc;
    wait_cyc(a + 20);
    chk("idle_led0", led0, 0);
    chk("idle_led1", led1, 1);
    chk("idle_ready", if0.req_ready, 1);
    send(2, a);
    wait_cyc(a + 1);
    chk("c2_led_1", led0, 1);
    wait_cyc(a + 3);
    chk("c2_led_3", led0, 1);
    wait_cyc(a + 4);
    chk("c2_led_4", led0, 0);
    wait_cyc(a + 6);
    chk("c2_led_6", led0, 1);
    wait_cyc(a + 10);
    chk("c2_led_10", led0, 0);
    chk("c2_busy_10", busy0, 1);
    wait_cyc(a + 11);
    chk("c2_done_11", done0, 1);
    chk("c2_ready_11", if0.req_ready, 1);
    wait_cyc(a + 12);
    chk("c2_done_12", done0, 0);
    send(0, a);
    wait_cyc(a + 1);
    chk("c0_done", done0, 1);
    chk("c0_led", led0, 0);
    chk("c0_ready", if0.req_ready, 1);
    wait_cyc(a + 2);
    chk("c0_done_after", done0, 0);
    @(posedge clk);
    #2 valid_s = 1'b1;
    count_s = 4'd1;
    a = cyc;
    wait_cyc(a + 5);
    chk("b2b_ready_5", if0.req_ready, 0);
    wait_cyc(a + 6);
    chk("b2b_done_6", done0, 1);
    wait_cyc(a + 7);
    chk("b2b_led_7", led0, 1);
    wait_cyc(a + 11);
    chk("b2b_led_11", led0, 0);
    wait_cyc(a + 12);
    chk("b2b_done_12", done0, 1);
    @(posedge clk);
    #2 valid_s = 1'b0;
    wait_cyc(a + 13);
    chk("b2b_led_13", led0, 1);
    wait_cyc(a + 18);
    chk("b2b_done_18", done0, 1);
    send(3, a);
    wait_cyc(a + 7);
    chk("rst_led_before", led0, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_led0", led0, 0);
    chk("rst_async_led1", led1, 1);
    chk("rst_async_busy", busy0, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    a = cyc;
    wait_cyc(a + 15);
    send(1, a);
    wait_cyc(a + 1);
    chk("post_rst_led", led0, 1);
    wait_cyc(a + 6);
    chk("post_rst_done", done0, 1);
    send(15, a);
    lows = 0;
    edges = 0;
    prev = 1'b1;
    for (int c = a + 1; c <= a + 76; c++) begin
      wait_cyc(c);
      lows += int'(!led1);
      edges += int'(prev && !led1);
      prev = led1;
      if (c == a + 75) chk("al_busy_75", busy1, 1);
      if (c == a + 76) begin
        chk("al_done_76", done1, 1);
        chk("al_led_76", led1, 1);
      end
    end
    chk("al_low_cycles", lows, 45);
    chk("al_low_phases", edges, 15);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2 valid_s = $urandom_range(0, 2) == 0;
      count_s = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if (i == 250) begin
        valid_s = 1'b0;
        #1 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(posedge clk);
    #2 valid_s = 1'b0;
    repeat (80) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
